// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built on one full-adder slice, LSB first.
// Optional SERIAL_SUB_EN adds a sub input that turns the operation into a-b.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_s, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c, r_cout, r_ovf;
    logic             w_sum, w_carry, w_last, w_accept, w_c_load;
    logic [WIDTH-1:0] w_b_load;

    assign w_sum    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry  = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = (r_state == IDLE) && start;

`ifdef SERIAL_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy   = 1'b0;
                w_next = start ? SHIFT : IDLE;
            end
            SHIFT: w_next = w_last ? DONE : SHIFT;
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= w_b_load;
            r_c   <= w_c_load;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_s   <= {w_sum, r_s[WIDTH-1:1]};
            r_c   <= w_carry;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            // r_c still holds the carry into the MSB on the final bit.
            if (w_last) begin
                r_sum  <= {w_sum, r_s[WIDTH-1:1]};
                r_cout <= w_carry;
                r_ovf  <= r_c ^ w_carry;
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the serial adder handshake, results and reset abort.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk, rst, start, cin;
    logic [WIDTH-1:0] a, b, sum;
    logic             cout, overflow, busy, done;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    int n_total = 0;
    int n_bad   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef SERIAL_SUB_EN
        .sub(sub),
`endif
        .sum(sum),
        .cout(cout),
        .overflow(overflow),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic ts, input bit jam, input logic [7:0] es, input logic ec, input logic eo);
        int lat, pulses;
        logic [7:0] s;
        logic c, o;
        lat = 0; pulses = 0; s = '0; c = 1'b0; o = 1'b0;
        a = ta; b = tb; cin = tc;
`ifdef SERIAL_SUB_EN
        sub = ts;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = jam;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= WIDTH + 6; i++) begin
            if (jam) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i; s = sum; c = cout; o = overflow;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk({tag, ".lat"}, 32'(lat), 32'(WIDTH));
        chk({tag, ".pulses"}, 32'(pulses), 32'd1);
        chk({tag, ".sum"}, 32'(s), 32'(es));
        chk({tag, ".cout"}, 32'(c), 32'(ec));
        chk({tag, ".ovf"}, 32'(o), 32'(eo));
        chk({tag, ".hold"}, 32'(sum), 32'(es));
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk); @(posedge clk); #1;
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        op("0f+01", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op("00+00+1", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
        op("aa+55+1jam", 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        op("7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort.sum", 32'(sum), 32'd0);
        chk("abort.cout", 32'(cout), 32'd0);
        chk("abort.ovf", 32'(overflow), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort.nodone", 32'(pulses), 32'd0);

        op("12+34", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
`ifdef SERIAL_SUB_EN
        op("05-07", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op("80-01", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
